// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter for N native-bus masters onto the single DDR controller port.
// One outstanding transaction; a streaming master may keep the port for MAX_BURST grants.
//
// state | meaning
// IDLE  | no transaction forwarded; pick a winner when any master is valid
// BUSY  | granted master's request forwarded; waiting for slave ready
module ext_mem_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int MAX_BURST = 4,
    parameter int REQ_W     = 69,
    parameter int RESP_W    = 33
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
);

    localparam int IDX_W   = $clog2(N_MASTERS);
    localparam int BURST_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     gidx;
    logic [BURST_W-1:0]   burst_cnt;

    logic [N_MASTERS-1:0] valid;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_found;
    logic                 keep;
    logic [IDX_W-1:0]     win_idx;
    logic [BURST_W-1:0]   win_cnt;
    int                   j;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Scan last+1 .. last+N; the final step lands on last itself, so a lone
    // requester always wins even after exhausting its burst allowance.
    always_comb begin
        rr_idx   = last;
        rr_found = 1'b0;
        j        = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            j = int'(last) + k;
            if (j >= N_MASTERS) begin
                j = j - N_MASTERS;
            end
            if (!rr_found && valid[j]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(j);
            end
        end
    end

    // burst_cnt == 0 only after reset: no retention, so master 0 wins first.
    always_comb begin
        keep = valid[last] && (burst_cnt != '0) && (burst_cnt < BURST_W'(MAX_BURST));
        if (keep) begin
            win_idx = last;
            win_cnt = burst_cnt + 1'b1;
        end else begin
            win_idx = rr_idx;
            win_cnt = BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            last      <= IDX_W'(N_MASTERS - 1);
            gidx      <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|valid) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        gidx      <= win_idx;
                        grant     <= N_MASTERS'(1) << win_idx;
                        burst_cnt <= win_cnt;
                    end
                end
                BUSY: begin
                    if (s_resp[0]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        grant <= '0;
                        last  <= gidx;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end

    // Muxing keys off the async-reset state so reset silences the port at once.
    always_comb begin
        s_req = '0;
        if (state == BUSY) begin
            s_req = m_req[gidx*REQ_W +: REQ_W];
        end
    end

    always_comb begin
        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((state == BUSY) && (gidx == IDX_W'(i))) begin
                m_resp[i*RESP_W +: RESP_W] = s_resp;
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: a 2-master/MAX_BURST=4 instance and a
// 3-master/MAX_BURST=1 instance sharing clock and reset.
module tb_ext_mem_arbiter;

    localparam int RQ = 69;
    localparam int RS = 33;

    logic clk;
    logic rst;

    logic [2*RQ-1:0] m_req2;
    logic [2*RS-1:0] m_resp2;
    logic [RQ-1:0]   s_req2;
    logic [RS-1:0]   s_resp2;
    logic [RS-1:0]   man_resp2;
    logic            auto2;
    logic [1:0]      grant2;
    logic            busy2;

    logic [3*RQ-1:0] m_req3;
    logic [3*RS-1:0] m_resp3;
    logic [RQ-1:0]   s_req3;
    logic [RS-1:0]   s_resp3;
    logic [2:0]      grant3;
    logic            busy3;

    int checks;
    int errors;

    // Auto slave: single-cycle, answers every forwarded request with a fixed read word.
    assign s_resp2 = auto2 ? {32'h1234_5678, s_req2[68]} : man_resp2;
    assign s_resp3 = {32'h1234_5678, s_req3[68]};

    ext_mem_arbiter #(.N_MASTERS(2), .MAX_BURST(4), .REQ_W(RQ), .RESP_W(RS)) dut2 (
        .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2),
        .s_req(s_req2), .s_resp(s_resp2), .grant(grant2), .busy(busy2)
    );

    ext_mem_arbiter #(.N_MASTERS(3), .MAX_BURST(1), .REQ_W(RQ), .RESP_W(RS)) dut3 (
        .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
        .s_req(s_req3), .s_resp(s_resp3), .grant(grant3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RQ-1:0] mk(input logic v, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic do_reset();
        rst       = 1'b0;
        m_req2    = '0;
        m_req3    = '0;
        man_resp2 = '0;
        auto2     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        m_req2 = {mk(1'b1, 32'h10, 32'h0, 4'h0), mk(1'b1, 32'h20, 32'h0, 4'h0)};
        auto2  = 1'b1;
        #3;
        checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy2); end
        checks++; if (s_req2 !== '0) begin errors++; $display("FAIL reset_s_req got %h want 0", s_req2); end
        checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL reset_m_resp got %h want 0", m_resp2); end
        checks++; if (grant3 !== 3'b000) begin errors++; $display("FAIL reset_grant3 got %b want 000", grant3); end
        do_reset();
    endtask

    task automatic test_single_master();
        logic [RQ-1:0] rq;
        do_reset();
        rq     = mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        m_req2 = {rq, {RQ{1'b0}}};
        @(negedge clk);
        checks++; if (s_req2 !== rq) begin errors++; $display("FAIL single_s_req got %h want %h", s_req2, rq); end
        checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL single_grant got %b want 10", grant2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy2); end
        checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL single_resp_wait got %h want 0", m_resp2); end
        repeat (2) begin
            @(negedge clk);
            checks++; if ((s_req2 !== rq) || (m_resp2 !== '0) || (grant2 !== 2'b10)) begin
                errors++; $display("FAIL single_hold s_req %h resp %h grant %b want %h 0 10", s_req2, m_resp2, grant2, rq);
            end
        end
        @(negedge clk);
        man_resp2 = {32'h0BAD_F00D, 1'b1};
        #1;
        checks++; if (m_resp2 !== {32'h0BAD_F00D, 1'b1, {RS{1'b0}}}) begin
            errors++; $display("FAIL single_resp got %h want %h", m_resp2, {32'h0BAD_F00D, 1'b1, {RS{1'b0}}});
        end
        @(negedge clk);
        m_req2    = '0;
        man_resp2 = '0;
        checks++; if ((grant2 !== 2'b00) || (busy2 !== 1'b0) || (s_req2 !== '0)) begin
            errors++; $display("FAIL single_done grant %b busy %b s_req %h want 00 0 0", grant2, busy2, s_req2);
        end
        @(negedge clk);
        checks++; if ((busy2 !== 1'b0) || (m_resp2 !== '0)) begin
            errors++; $display("FAIL single_idle busy %b resp %h want 0 0", busy2, m_resp2);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg;
        int m;
        do_reset();
        m_req3 = {mk(1'b1, 32'h300, 32'h0, 4'h0), mk(1'b1, 32'h200, 32'h0, 4'h0),
                  mk(1'b1, 32'h100, 32'h0, 4'h0)};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (busy3 !== (i % 2 == 0)) begin
                errors++; $display("FAIL rr_busy cycle %0d got %b want %b", i, busy3, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                m  = (i / 2) % 3;
                eg = 3'b001 << m;
                checks++; if (grant3 !== eg) begin errors++; $display("FAIL rr_grant cycle %0d got %b want %b", i, grant3, eg); end
                checks++; if ({m_resp3[2*RS], m_resp3[RS], m_resp3[0]} !== eg) begin
                    errors++; $display("FAIL rr_ready cycle %0d got %b want %b", i, {m_resp3[2*RS], m_resp3[RS], m_resp3[0]}, eg);
                end
                checks++; if (s_req3[67:36] !== 32'((m + 1) * 32'h100)) begin
                    errors++; $display("FAIL rr_addr cycle %0d got %h want %h", i, s_req3[67:36], (m + 1) * 32'h100);
                end
            end
        end
        m_req3 = '0;
    endtask

    task automatic test_burst_retention();
        int t;
        int m;
        do_reset();
        auto2  = 1'b1;
        m_req2 = {mk(1'b1, 32'h2000, 32'h0, 4'h0), mk(1'b1, 32'h1000, 32'h0, 4'h0)};
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                t = i / 2;
                m = (t / 4) % 2;
                checks++; if (grant2 !== (2'b01 << m)) begin
                    errors++; $display("FAIL burst_grant txn %0d got %b want %b", t, grant2, 2'b01 << m);
                end
                checks++; if ((m_resp2[m*RS +: RS] !== {32'h1234_5678, 1'b1}) || (m_resp2[(1-m)*RS +: RS] !== '0)) begin
                    errors++; $display("FAIL burst_rdata txn %0d got %h want master %0d only", t, m_resp2, m);
                end
            end else begin
                checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL burst_idle cycle %0d got %b want 0", i, busy2); end
            end
        end
        m_req2 = '0;
        auto2  = 1'b0;
    endtask

    task automatic test_lone_streamer();
        do_reset();
        auto2  = 1'b1;
        m_req2 = {mk(1'b1, 32'h4000, 32'h0, 4'h0), {RQ{1'b0}}};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (busy2 !== (i % 2 == 0)) begin
                errors++; $display("FAIL lone_busy cycle %0d got %b want %b", i, busy2, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                checks++; if ((grant2 !== 2'b10) || (m_resp2[RS] !== 1'b1)) begin
                    errors++; $display("FAIL lone_grant txn %0d grant %b ready %b want 10 1", i / 2, grant2, m_resp2[RS]);
                end
            end
        end
        m_req2 = '0;
        auto2  = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req2 = {mk(1'b1, 32'h500, 32'h0, 4'h0), {RQ{1'b0}}};
        @(negedge clk);
        checks++; if ((busy2 !== 1'b1) || (grant2 !== 2'b10)) begin
            errors++; $display("FAIL mid_pre busy %b grant %b want 1 10", busy2, grant2);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if ((s_req2[68] !== 1'b0) || (grant2 !== 2'b00) || (busy2 !== 1'b0)) begin
            errors++; $display("FAIL mid_async valid %b grant %b busy %b want 0 00 0", s_req2[68], grant2, busy2);
        end
        @(negedge clk);
        rst    = 1'b1;
        m_req2 = {mk(1'b1, 32'h500, 32'h0, 4'h0), mk(1'b1, 32'h600, 32'h0, 4'h0)};
        @(negedge clk);
        checks++; if ((grant2 !== 2'b01) || (s_req2[67:36] !== 32'h600)) begin
            errors++; $display("FAIL mid_first grant %b addr %h want 01 600", grant2, s_req2[67:36]);
        end
        man_resp2 = {32'h0, 1'b1};
        @(negedge clk);
        m_req2    = '0;
        man_resp2 = '0;
        @(negedge clk);
    endtask

    task automatic test_spurious_and_drop();
        do_reset();
        man_resp2 = {32'hCAFE_F00D, 1'b1};
        @(negedge clk);
        checks++; if ((m_resp2 !== '0) || (busy2 !== 1'b0)) begin
            errors++; $display("FAIL spur_idle resp %h busy %b want 0 0", m_resp2, busy2);
        end
        man_resp2 = '0;
        m_req2    = {{RQ{1'b0}}, mk(1'b1, 32'h700, 32'h1, 4'h3)};
        @(negedge clk);
        checks++; if ((busy2 !== 1'b1) || (grant2 !== 2'b01)) begin
            errors++; $display("FAIL drop_grant busy %b grant %b want 1 01", busy2, grant2);
        end
        m_req2 = {{RQ{1'b0}}, mk(1'b0, 32'h700, 32'h1, 4'h3)};
        #1;
        checks++; if (s_req2 !== mk(1'b0, 32'h700, 32'h1, 4'h3)) begin
            errors++; $display("FAIL drop_fwd got %h want %h", s_req2, mk(1'b0, 32'h700, 32'h1, 4'h3));
        end
        repeat (2) begin
            @(negedge clk);
            checks++; if ((busy2 !== 1'b1) || (grant2 !== 2'b01) || (s_req2[68] !== 1'b0)) begin
                errors++; $display("FAIL drop_hold busy %b grant %b valid %b want 1 01 0", busy2, grant2, s_req2[68]);
            end
        end
        man_resp2 = {32'h0000_00AA, 1'b1};
        #1;
        checks++; if (m_resp2 !== {{RS{1'b0}}, 32'h0000_00AA, 1'b1}) begin
            errors++; $display("FAIL drop_ready got %h want %h", m_resp2, {{RS{1'b0}}, 32'h0000_00AA, 1'b1});
        end
        @(negedge clk);
        checks++; if ((busy2 !== 1'b0) || (grant2 !== 2'b00) || (m_resp2 !== '0)) begin
            errors++; $display("FAIL drop_exit busy %b grant %b resp %h want 0 00 0", busy2, grant2, m_resp2);
        end
        @(negedge clk);
        checks++; if ((busy2 !== 1'b0) || (m_resp2 !== '0)) begin
            errors++; $display("FAIL spur_idle2 busy %b resp %h want 0 0", busy2, m_resp2);
        end
        man_resp2 = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        m_req2    = '0;
        m_req3    = '0;
        man_resp2 = '0;
        auto2     = 1'b0;
        test_reset();
        test_single_master();
        test_round_robin();
        test_burst_retention();
        test_lone_streamer();
        test_reset_mid();
        test_spurious_and_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
